// File: rtl/qs_pkg.sv
// Shared types and header-field constants for the QS command framer.
// Header layout: [7] action, [6:5] reserved, [4:0] payload length.
package qs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_RESP
    } state_t;

    localparam int ACT_BIT = 7;
    localparam int LEN_MSB = 4;
    localparam int LEN_LSB = 0;
    localparam int MAX_LEN = 31;

    // A header length is usable only if it is non-zero and fits the buffer.
    function automatic logic hdr_len_ok(input logic [LEN_MSB-LEN_LSB:0] len, input int depth);
        return (len != '0) && (int'(len) <= depth);
    endfunction

endpackage

// File: rtl/qs_pkt_buf.sv
// Payload store for one packet: synchronous write, asynchronous read.
// The array is deliberately not reset; the pointers decide what is valid.
module qs_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/qs_cmd_framer.sv
// Buffers one length-prefixed host packet, replays it to QS as a contiguous
// burst, then waits for the QS response (or a timeout) before the next one.
module qs_cmd_framer
    import qs_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_valid,
    input  logic [7:0] host_data,
    output logic       host_ready,
    output logic       in_valid,
    output logic [7:0] in_data,
    output logic       action,
    input  logic       out_valid,
    output logic       err
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t state_reg, state_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] len_reg, len_next;
    logic          act_reg, act_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic          ov_prev_reg;
    logic          in_valid_reg, in_valid_next;
    logic [7:0]    in_data_reg, in_data_next;
    logic          action_reg, action_next;
    logic          err_reg, err_next;

    logic                     host_xfer;
    logic                     buf_we;
    logic [AW-1:0]            buf_rd_addr;
    logic [7:0]               buf_rd_data;
    logic [LEN_MSB-LEN_LSB:0] hdr_len;
    logic [PW-1:0]            wr_ptr_inc;

    assign host_ready  = (state_reg == IDLE) || (state_reg == LOAD);
    assign host_xfer   = host_valid && host_ready;
    assign hdr_len     = host_data[LEN_MSB:LEN_LSB];
    assign wr_ptr_inc  = wr_ptr_reg + PW'(1);
    assign buf_rd_addr = (state_reg == SEND) ? rd_ptr_reg[AW-1:0] : '0;

    qs_pkt_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data (host_data),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        len_next      = len_reg;
        act_next      = act_reg;
        to_cnt_next   = to_cnt_reg;
        in_valid_next = 1'b0;
        in_data_next  = 8'h00;
        action_next   = 1'b0;
        err_next      = 1'b0;
        buf_we        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (host_xfer) begin
                    if (hdr_len_ok(hdr_len, DEPTH)) begin
                        len_next    = PW'(hdr_len);
                        act_next    = host_data[ACT_BIT];
                        wr_ptr_next = '0;
                        state_next  = LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (host_xfer) begin
                    buf_we      = 1'b1;
                    wr_ptr_next = wr_ptr_inc;
                    // The first beat is launched on the same edge as the last write;
                    // for a one-byte packet that byte is still on host_data.
                    if (wr_ptr_inc == len_reg) begin
                        state_next    = SEND;
                        in_valid_next = 1'b1;
                        in_data_next  = (wr_ptr_reg == '0) ? host_data : buf_rd_data;
                        action_next   = act_reg;
                        rd_ptr_next   = PW'(1);
                    end
                end
            end
            SEND: begin
                if (rd_ptr_reg < len_reg) begin
                    in_valid_next = 1'b1;
                    in_data_next  = buf_rd_data;
                    action_next   = act_reg;
                    rd_ptr_next   = rd_ptr_reg + PW'(1);
                end else begin
                    to_cnt_next = '0;
                    state_next  = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (!out_valid && ov_prev_reg) begin
                    state_next = IDLE;
                end else if (to_cnt_reg == TO_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            len_reg      <= '0;
            act_reg      <= 1'b0;
            to_cnt_reg   <= '0;
            ov_prev_reg  <= 1'b0;
            in_valid_reg <= 1'b0;
            in_data_reg  <= 8'h00;
            action_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            len_reg      <= len_next;
            act_reg      <= act_next;
            to_cnt_reg   <= to_cnt_next;
            // Only response activity seen while waiting can form a falling edge.
            ov_prev_reg  <= (state_reg == WAIT_RESP) && out_valid;
            in_valid_reg <= in_valid_next;
            in_data_reg  <= in_data_next;
            action_reg   <= action_next;
            err_reg      <= err_next;
        end
    end

    assign in_valid = in_valid_reg;
    assign in_data  = in_data_reg;
    assign action   = action_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_qs_cmd_framer.sv
// Self-checking bench for qs_cmd_framer: randomized packets compared against
// expected bursts derived from header/payload arithmetic and cycle timing.
module tb_qs_cmd_framer;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_valid = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       out_valid = 1'b0;
    logic       host_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       action;
    logic       err;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int last_ready_cyc = -1;
    int zero_viol = 0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       act;
    } beat_t;

    beat_t obs_q[$];
    int    err_q[$];
    beat_t cap_b;

    qs_cmd_framer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_ready (host_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .action     (action),
        .out_valid  (out_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive capture of everything the DUT emits, tagged with the cycle number.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid) begin
                cap_b.cyc  = cyc;
                cap_b.data = in_data;
                cap_b.act  = action;
                obs_q.push_back(cap_b);
            end else if (in_data !== 8'h00 || action !== 1'b0) begin
                zero_viol++;
            end
            if (err) err_q.push_back(cyc);
            if (host_ready) last_ready_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit, compared=%0d mismatched=%0d", compared, mismatched);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking of DUT outputs) -------------

    task automatic drive_byte(input logic [7:0] b, output int t_acc);
        int w;
        w = 0;
        t_acc = -1;
        forever begin
            @(negedge clk);
            host_valid = 1'b1;
            host_data  = b;
            if (host_ready) begin
                t_acc = cyc;
                break;
            end
            w++;
            if (w > 100) begin
                compared++;
                mismatched++;
                $display("FAIL host_accept: host_ready stayed 0 for %0d cycles, want 1", w);
                break;
            end
        end
    endtask

    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] pl[$],
                               input int gap, input bit toggle, output int t_last);
        int t;
        drive_byte(hdr, t);
        t_last = t;
        foreach (pl[k]) begin
            repeat (gap) begin
                @(negedge clk);
                host_valid = 1'b0;
                host_data  = 8'($urandom);
                if (toggle) out_valid = ~out_valid;
            end
            out_valid = 1'b0;
            drive_byte(pl[k], t_last);
        end
        @(negedge clk);
        host_valid = 1'b0;
        out_valid  = 1'b0;
    endtask

    task automatic respond(input int lat, input int len, output int c);
        repeat (lat) begin
            @(negedge clk);
            out_valid = 1'b0;
        end
        repeat (len) begin
            @(negedge clk);
            out_valid = 1'b1;
        end
        c = cyc;
        @(negedge clk);
        out_valid = 1'b0;
    endtask

    // ---------------- scenario tests ----------------

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if ({host_ready, in_valid, in_data, action, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_hold: got rdy=%0b iv=%0b id=%02h act=%0b err=%0b, want 1 0 00 0 0",
                     host_ready, in_valid, in_data, action, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        compared++;
        if ({host_ready, in_valid, in_data, action, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_release: got rdy=%0b iv=%0b id=%02h act=%0b err=%0b, want 1 0 00 0 0",
                     host_ready, in_valid, in_data, action, err);
        end
        $display("txn reset: done");
    endtask

    task automatic test_basic;
        logic [7:0] pl[$];
        int base, t_last, c;
        pl = '{8'h11, 8'h22, 8'h33};
        base = obs_q.size();
        send_packet(8'h83, pl, 0, 1'b0, t_last);
        repeat (pl.size() + 1) @(negedge clk);
        #1;
        compared++;
        if (obs_q.size() - base != pl.size()) begin
            mismatched++;
            $display("FAIL basic_len: got %0d beats, want %0d", obs_q.size() - base, pl.size());
        end
        for (int k = 0; k < pl.size() && base + k < obs_q.size(); k++) begin
            compared++;
            if (obs_q[base+k].data !== pl[k] || obs_q[base+k].act !== 1'b1 || obs_q[base+k].cyc != t_last + 1 + k) begin
                mismatched++;
                $display("FAIL basic_beat%0d: got %02h/%0b@%0d, want %02h/1@%0d",
                         k, obs_q[base+k].data, obs_q[base+k].act, obs_q[base+k].cyc, pl[k], t_last + 1 + k);
            end
        end
        respond(3, 2, c);
        #1;
        compared++;
        if (host_ready !== 1'b0 || last_ready_cyc != t_last) begin
            mismatched++;
            $display("FAIL basic_ready_low: got rdy=%0b last_ready=%0d, want 0 and %0d", host_ready, last_ready_cyc, t_last);
        end
        @(negedge clk);
        #1;
        compared++;
        if (host_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_ready_back: got %0b at c+2, want 1", host_ready);
        end
        $display("txn basic: hdr=83 n=3 last_accept=%0d resp_end=%0d", t_last, c);
    endtask

    task automatic test_boundary;
        logic [7:0] pl[$];
        int base, t_last, c, n;
        for (int i = 0; i < 2; i++) begin
            n = (i == 0) ? 1 : DEPTH;
            pl = {};
            repeat (n) pl.push_back(8'($urandom));
            base = obs_q.size();
            send_packet(8'(n), pl, 0, 1'b0, t_last);
            repeat (n + 1) @(negedge clk);
            #1;
            compared++;
            if (obs_q.size() - base != n) begin
                mismatched++;
                $display("FAIL boundary_len_n%0d: got %0d beats, want %0d", n, obs_q.size() - base, n);
            end
            for (int k = 0; k < n && base + k < obs_q.size(); k++) begin
                compared++;
                if (obs_q[base+k].data !== pl[k] || obs_q[base+k].act !== 1'b0 || obs_q[base+k].cyc != t_last + 1 + k) begin
                    mismatched++;
                    $display("FAIL boundary_n%0d_beat%0d: got %02h/%0b@%0d, want %02h/0@%0d",
                             n, k, obs_q[base+k].data, obs_q[base+k].act, obs_q[base+k].cyc, pl[k], t_last + 1 + k);
                end
            end
            respond(1, 1, c);
            $display("txn boundary: n=%0d last_accept=%0d", n, t_last);
        end
    endtask

    task automatic test_illegal;
        logic [7:0] pl[$];
        int base, base_e, t1, t2, e0, e1, t_last, c;
        base   = obs_q.size();
        base_e = err_q.size();
        drive_byte(8'h00, t1);
        repeat (2) begin
            @(negedge clk);
            host_valid = 1'b0;
        end
        drive_byte(8'h11, t2);
        @(negedge clk);
        host_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        e0 = (err_q.size() > base_e) ? err_q[base_e] : -1;
        e1 = (err_q.size() > base_e + 1) ? err_q[base_e+1] : -1;
        compared++;
        if (err_q.size() - base_e != 2 || e0 != t1 + 1 || e1 != t2 + 1) begin
            mismatched++;
            $display("FAIL illegal_err: got %0d pulses at %0d,%0d, want 2 at %0d,%0d",
                     err_q.size() - base_e, e0, e1, t1 + 1, t2 + 1);
        end
        compared++;
        if (obs_q.size() != base || host_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL illegal_idle: got beats=%0d rdy=%0b, want 0 and 1", obs_q.size() - base, host_ready);
        end
        pl = '{8'($urandom), 8'($urandom)};
        base = obs_q.size();
        send_packet(8'h82, pl, 0, 1'b0, t_last);
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (obs_q.size() - base != 2) begin
            mismatched++;
            $display("FAIL illegal_next_len: got %0d beats, want 2", obs_q.size() - base);
        end
        for (int k = 0; k < 2 && base + k < obs_q.size(); k++) begin
            compared++;
            if (obs_q[base+k].data !== pl[k] || obs_q[base+k].act !== 1'b1 || obs_q[base+k].cyc != t_last + 1 + k) begin
                mismatched++;
                $display("FAIL illegal_next_beat%0d: got %02h/%0b@%0d, want %02h/1@%0d",
                         k, obs_q[base+k].data, obs_q[base+k].act, obs_q[base+k].cyc, pl[k], t_last + 1 + k);
            end
        end
        respond(0, 3, c);
        $display("txn illegal: hdrs 00,11 at %0d,%0d then 82", t1, t2);
    endtask

    task automatic test_timeout;
        logic [7:0] pl[$];
        int base, base_e, t_last, n, w, e0;
        n = $urandom_range(1, DEPTH);
        pl = {};
        repeat (n) pl.push_back(8'($urandom));
        base   = obs_q.size();
        base_e = err_q.size();
        send_packet({1'b1, 2'($urandom), 5'(n)}, pl, 0, 1'b0, t_last);
        w = t_last + n + 1;
        while (cyc < w + TIMEOUT + 1) @(negedge clk);
        #1;
        e0 = (err_q.size() > base_e) ? err_q[base_e] : -1;
        compared++;
        if (err_q.size() - base_e != 1 || e0 != w + TIMEOUT) begin
            mismatched++;
            $display("FAIL timeout_err: got %0d pulses first at %0d, want 1 at %0d", err_q.size() - base_e, e0, w + TIMEOUT);
        end
        compared++;
        if (host_ready !== 1'b1 || obs_q.size() - base != n) begin
            mismatched++;
            $display("FAIL timeout_idle: got rdy=%0b beats=%0d, want 1 and %0d", host_ready, obs_q.size() - base, n);
        end
        $display("txn timeout: n=%0d wait_entry=%0d err_at=%0d", n, w, e0);
    endtask

    task automatic test_stalls;
        logic [7:0] pl[$];
        int base, base_e, t_last, n, c;
        n = $urandom_range(4, 10);
        pl = {};
        repeat (n) pl.push_back(8'($urandom));
        base   = obs_q.size();
        base_e = err_q.size();
        send_packet({1'b0, 2'($urandom), 5'(n)}, pl, 5, 1'b1, t_last);
        repeat (n + 1) @(negedge clk);
        #1;
        compared++;
        if (obs_q.size() - base != n || err_q.size() != base_e) begin
            mismatched++;
            $display("FAIL stall_len: got %0d beats %0d errs, want %0d beats 0 errs",
                     obs_q.size() - base, err_q.size() - base_e, n);
        end
        for (int k = 0; k < n && base + k < obs_q.size(); k++) begin
            compared++;
            if (obs_q[base+k].data !== pl[k] || obs_q[base+k].act !== 1'b0 || obs_q[base+k].cyc != t_last + 1 + k) begin
                mismatched++;
                $display("FAIL stall_beat%0d: got %02h/%0b@%0d, want %02h/0@%0d",
                         k, obs_q[base+k].data, obs_q[base+k].act, obs_q[base+k].cyc, pl[k], t_last + 1 + k);
            end
        end
        respond(2, 2, c);
        $display("txn stalls: n=%0d last_accept=%0d", n, t_last);
    endtask

    task automatic test_reset_mid;
        logic [7:0] pl[$];
        int base, t_last, n, c;
        logic a;
        pl = {};
        repeat (8) pl.push_back(8'($urandom));
        base = obs_q.size();
        send_packet(8'h88, pl, 0, 1'b0, t_last);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({host_ready, in_valid, in_data, action, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL midreset_outputs: got rdy=%0b iv=%0b id=%02h act=%0b err=%0b, want 1 0 00 0 0",
                     host_ready, in_valid, in_data, action, err);
        end
        compared++;
        if (obs_q.size() - base != 2 || obs_q[base].data !== pl[0] || obs_q[base+1].data !== pl[1]) begin
            mismatched++;
            $display("FAIL midreset_partial: got %0d beats before reset, want 2 (%02h %02h)",
                     obs_q.size() - base, pl[0], pl[1]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = $urandom_range(1, DEPTH);
        a = 1'($urandom);
        pl = {};
        repeat (n) pl.push_back(8'($urandom));
        base = obs_q.size();
        send_packet({a, 2'($urandom), 5'(n)}, pl, 0, 1'b0, t_last);
        repeat (n + 1) @(negedge clk);
        #1;
        compared++;
        if (obs_q.size() - base != n) begin
            mismatched++;
            $display("FAIL midreset_next_len: got %0d beats, want %0d", obs_q.size() - base, n);
        end
        for (int k = 0; k < n && base + k < obs_q.size(); k++) begin
            compared++;
            if (obs_q[base+k].data !== pl[k] || obs_q[base+k].act !== a || obs_q[base+k].cyc != t_last + 1 + k) begin
                mismatched++;
                $display("FAIL midreset_next_beat%0d: got %02h/%0b@%0d, want %02h/%0b@%0d",
                         k, obs_q[base+k].data, obs_q[base+k].act, obs_q[base+k].cyc, pl[k], a, t_last + 1 + k);
            end
        end
        respond(1, 1, c);
        $display("txn reset_mid: next n=%0d act=%0b", n, a);
    endtask

    task automatic test_random;
        logic [7:0] pl[$];
        int base, t_last, n, c;
        logic a;
        for (int p = 0; p < 8; p++) begin
            n = $urandom_range(1, DEPTH);
            a = 1'($urandom);
            pl = {};
            repeat (n) pl.push_back(8'($urandom));
            base = obs_q.size();
            send_packet({a, 2'($urandom), 5'(n)}, pl, $urandom_range(0, 2), 1'($urandom), t_last);
            repeat (n + 1) @(negedge clk);
            #1;
            compared++;
            if (obs_q.size() - base != n) begin
                mismatched++;
                $display("FAIL rand%0d_len: got %0d beats, want %0d", p, obs_q.size() - base, n);
            end
            for (int k = 0; k < n && base + k < obs_q.size(); k++) begin
                compared++;
                if (obs_q[base+k].data !== pl[k] || obs_q[base+k].act !== a || obs_q[base+k].cyc != t_last + 1 + k) begin
                    mismatched++;
                    $display("FAIL rand%0d_beat%0d: got %02h/%0b@%0d, want %02h/%0b@%0d",
                             p, k, obs_q[base+k].data, obs_q[base+k].act, obs_q[base+k].cyc, pl[k], a, t_last + 1 + k);
                end
            end
            respond($urandom_range(0, 6), $urandom_range(1, 4), c);
            #1;
            compared++;
            if (host_ready !== 1'b0 || last_ready_cyc != t_last) begin
                mismatched++;
                $display("FAIL rand%0d_ready_low: got rdy=%0b last_ready=%0d, want 0 and %0d",
                         p, host_ready, last_ready_cyc, t_last);
            end
            @(negedge clk);
            #1;
            compared++;
            if (host_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL rand%0d_ready_back: got %0b, want 1", p, host_ready);
            end
            $display("txn random%0d: n=%0d act=%0b last_accept=%0d resp_end=%0d", p, n, a, t_last, c);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_illegal();
        test_timeout();
        test_stalls();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (err_q.size() != 3) begin
            mismatched++;
            $display("FAIL err_total: got %0d err pulses overall, want 3", err_q.size());
        end
        compared++;
        if (zero_viol != 0) begin
            mismatched++;
            $display("FAIL idle_zero: got %0d cycles with nonzero in_data/action while in_valid=0, want 0", zero_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/qs_cmd_framer.md
# qs_cmd_framer

Upstream feeder for the QS block. Accepts length-prefixed command packets from a byte-wide host interface and buffers each packet completely. It then replays the packet into QS as one contiguous `in_valid` burst with a constant `action`. Before accepting the next packet, it waits for QS to finish its response (`out_valid` burst).

## Interface
- `DEPTH`, 16: payload buffer depth in bytes; also the maximum legal packet length (power of 2, at most 31).
- `TIMEOUT`, 1024: cycles allowed in WAIT_RESP before abort.
- `clk` in 1: single clock; all state on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `host_valid` in 1: host byte valid.
- `host_data` in 8: host byte (header or payload).
- `host_ready` out 1: framer can accept a host byte.
- `in_valid` out 1: to QS, burst valid.
- `in_data` out 8: to QS, payload byte.
- `action` out 1: to QS, packet action bit.
- `out_valid` in 1: from QS, response valid (monitored only; data not consumed).
- `err` out 1: one-cycle pulse on an illegal header or a response timeout.

## Operation
- **Transfer rule:** a host transfer occurs on any cycle with `host_valid && host_ready`.
- **Header byte:**
  - `[7]` is the action bit A.
  - `[6:5]` are reserved and ignored.
  - `[4:0]` is the length N.
  - Legal range is 1 ≤ N ≤ DEPTH.
- **States:** IDLE → LOAD → SEND → WAIT_RESP → IDLE.
- **IDLE:** `host_ready` = 1.
  - Legal header: latch A and N, clear the write pointer, go to LOAD.
  - Illegal header (N = 0 or N > DEPTH): pulse `err` next cycle, discard the byte, stay in IDLE.
- **LOAD:** `host_ready` = 1.
  - Each transfer writes the buffer at the write pointer and increments it.
  - The N-th transfer moves to SEND.
- **SEND:** `host_ready` = 0.
  - For exactly N consecutive cycles: `in_valid` = 1, `in_data` = buffer[k] for k = 0..N-1 in arrival order, `action` = A on every cycle.
  - After the last byte, go to WAIT_RESP and clear the timeout counter.
- **WAIT_RESP:** `host_ready` = 0.
  - Track `out_valid`. The response is complete on the first cycle where `out_valid` = 0 after having been 1 (falling edge); then go to IDLE.
  - If the counter reaches TIMEOUT-1 with no falling edge: pulse `err` and go to IDLE.
  - A response still in progress at timeout is ignored from then on.
- **Stray responses:** `out_valid` in IDLE, LOAD or SEND is ignored and raises no error.
- **Host stall:** `host_valid` low mid-LOAD holds state indefinitely; there is no LOAD timeout.
- **Width rules:**
  - Write/read pointers are $clog2(DEPTH)+1 bits, so a count of DEPTH is representable.
  - The timeout counter is $clog2(TIMEOUT) bits and saturates; it never wraps.

## Timing
- **Reset values:** state = IDLE, `in_valid` = 0, `in_data` = 0, `action` = 0, `err` = 0, pointers and counters = 0.
- `host_ready` is decoded from state, so it reads 1 during and immediately after reset.
- **Registered outputs:** `in_valid`, `in_data`, `action` and `err` are registered. `in_data` and `action` are 0 whenever `in_valid` = 0.
- **Header to payload:** header accepted at cycle t → payload can be accepted from t+1.
- **Payload to burst:** last payload byte accepted at t → `host_ready` = 0 at t+1, and `in_valid` is high for cycles t+1 .. t+N.
- **N = 1:** the burst is a single cycle.
- **Response to next packet:** `out_valid` 1 at cycle c and 0 at c+1 → state is IDLE and `host_ready` = 1 at c+2.
- **Minimum packet turnaround:** N+1 accept cycles + N send cycles + QS latency + 2.
- **Error pulse:** illegal header accepted at t → `err` = 1 at t+1 only.
- **Timeout:** `err` fires TIMEOUT cycles after WAIT_RESP entry.
- **Reset mid-operation:** asserting `rst_n` low in any state immediately forces the reset values. A partial packet or burst is dropped and never resumed.

## Structure
- **Package `qs_pkg`:**
  - state enum (IDLE, LOAD, SEND, WAIT_RESP);
  - header field constants (ACT_BIT = 7, LEN_MSB = 4, LEN_LSB = 0);
  - MAX_LEN = 31.
- **Sub-module `qs_pkt_buf`:**
  - DEPTH×8 register array with write-enable/write-pointer and read-pointer ports;
  - asynchronous read, synchronous write;
  - no reset on the storage array.
- **Top level:** FSM, pointers, timeout counter and output registers.

## Test plan
- **Basic packet:** header 0x83, payload 0x11, 0x22, 0x33 → `in_valid` high 3 consecutive cycles, `in_data` 0x11/0x22/0x33, `action` = 1. `host_ready` stays 0 until 2 cycles after the `out_valid` falling edge.
- **Boundary lengths:** header 0x01 (N = 1) and 0x10 (N = 16) → single-cycle burst and 16-cycle burst respectively, with data in arrival order and `action` = 0.
- **Illegal headers:** header 0x00, then 0x11 (N = 17) → two `err` pulses, no `in_valid`, still IDLE. A following legal 0x82 packet works normally.
- **Response timeout:** legal packet, `out_valid` never asserted → `err` exactly TIMEOUT cycles after WAIT_RESP entry, `host_ready` = 1 the next cycle.
- **Stalls and stray responses:** `host_valid` gaps of 5 cycles inside the payload and `out_valid` toggling during LOAD → burst unchanged and contiguous, no `err`.
- **Reset mid-operation:** `rst_n` pulsed low mid-SEND (after 2 of 8 bytes) → `in_valid` drops immediately, all outputs at reset values. The next packet is emitted correctly from its first byte.
